midi_voice_alloc: RTL and testbench
===================================

// Module: midi_voice_alloc
// PURPOSE
//  Polyphonic voice allocator between midi_ctrl and the synth voice bank, in the clk32 domain.
//  Consumes note-on/note-off pulses and maps each note to one of NUM_VOICES voice slots.
//  Per-slot outputs are gate, note, velocity and trigger.
//  Free slots are preferred; otherwise the least-recently-allocated slot is stolen, or the note is dropped.
// PARAMETERS
//  NUM_VOICES  4  number of voice slots, 2..8
//  OMNI        1  1 = accept all MIDI channels; 0 = accept only CHANNEL
//  CHANNEL     0  accepted MIDI channel (0..15) when OMNI=0
// PORTS
//  clk32          in   1            system clock
//  rst            in   1            synchronous reset, active-high
//  note_pressed   in   1            1-cycle note-on pulse from midi_ctrl
//  note_released  in   1            1-cycle note-off pulse from midi_ctrl
//  note           in   7            note number, valid with pulse
//  velocity       in   7            velocity, valid with pulse
//  channel        in   4            MIDI channel, valid with pulse
//  voice_gate     out  NUM_VOICES   per-slot gate, held while note is on
//  voice_trig     out  NUM_VOICES   1-cycle pulse when slot is (re)assigned
//  voice_note     out  7*NUM_VOICES packed note per slot; slot i = [7i+6:7i]
//  voice_vel      out  7*NUM_VOICES packed velocity per slot
//  active_cnt     out  4            number of gated slots
//  drop_cnt       out  8            saturating count of dropped note-ons
// BEHAVIOUR
//  Reset: all outputs 0; rank[i]=i (rank 0 = newest, NUM_VOICES-1 = oldest).
//  Input filtering:
//   - Events on a non-accepted channel are ignored.
//   - note_pressed with velocity=0 is treated as a release.
//  Latency: every output updates on the clk32 edge after the event pulse (1 cycle).
//  Note-on priority, first match wins:
//   (a) A gated slot with the same note and channel: retrigger it. vel is updated and trig pulses.
//   (b) The lowest-index ungated slot.
//   (c) All slots gated:
//       - VOICE_STEAL_EN defined: steal the slot with rank NUM_VOICES-1.
//       - Not defined: drop the note; drop_cnt += 1, saturating at 255.
//  Allocation:
//   - The chosen slot gets gate=1, note/vel/channel loaded, trig=1, rank=0.
//   - Every slot whose old rank is below the chosen slot's old rank gets rank+1.
//   - Ranks remain a permutation of 0..NUM_VOICES-1 at all times.
//  Note-off:
//   - Clears gate on every gated slot matching note+channel.
//   - note/vel are kept, so the release tail can use them. Rank is unchanged.
//   - A note-off with no match is a no-op.
//  note_pressed and note_released in the same cycle: the release is applied, the press is ignored.
//  active_cnt is registered and equals popcount(voice_gate) after each update.
//  rst mid-operation: all gates and trigs drop on the next edge; ranks reinitialise.
// CONFIGURATION
//  `VOICE_STEAL_EN`
//   - Defined: steal the oldest slot when full; drop_cnt stays 0.
//   - Not defined: drop the note when full; drop_cnt counts drops.
// STRUCTURE
//  Package synth_voice_pkg: NOTE_W=7, VEL_W=7, CHAN_W=4, RANK_W=3, typedef voice_t {gate,note,vel,chan}.
//  Sub-module voice_rank_tracker:
//   - Holds the rank registers.
//   - Inputs: alloc pulse and slot index.
//   - Outputs: oldest-slot index.
//  The allocator top holds match/free search, slot registers and counters.
// TESTING
//  1. After reset: on(60,100) -> next cycle gate=0001, trig=0001, note0=60, vel0=100, active_cnt=1.
//  2. on(60),on(62),on(64),on(67), then off(62) -> gate=1101; note1 stays 62.
//     Then on(70) -> lands in slot 1.
//  3. Full with VOICE_STEAL_EN defined:
//     on 60,62,64,67 then on(72) -> slot 0 (oldest) gets 72; trig=0001; gate=1111.
//  4. Full without VOICE_STEAL_EN: on(72) -> no change; drop_cnt=1.
//     300 further drops -> drop_cnt=255.
//  5. Retrigger and velocity-0:
//     on(60,100) then on(60,50) -> slot 0 only, vel0=50, trig pulses twice, active_cnt=1.
//     on(60,vel=0) -> gate0=0.
//  6. OMNI=0, CHANNEL=2: on(60) on ch3 -> ignored.
//     Same-cycle press+release on ch2 -> release only.
//     rst asserted while gate=1111 -> all outputs 0 next edge.

Source files
------------

// File: rtl/synth_voice_pkg.sv
// Shared widths, slot record and helpers for the MIDI voice allocator.
package synth_voice_pkg;
  localparam int NOTE_W = 7;
  localparam int VEL_W  = 7;
  localparam int CHAN_W = 4;
  localparam int RANK_W = 3;

  typedef struct packed {
    logic              gate;
    logic [NOTE_W-1:0] note;
    logic [VEL_W-1:0]  vel;
    logic [CHAN_W-1:0] chan;
  } voice_t;

  function automatic logic [3:0] count_gates(input logic [7:0] g);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'b0, g[i]};
    return c;
  endfunction
endpackage

// File: rtl/voice_rank_tracker.sv
// Allocation-age ranks per voice slot (0 = newest); reports the oldest slot.
module voice_rank_tracker
  import synth_voice_pkg::*;
#(
  parameter int NUM_VOICES = 4
) (
  input  logic              i_clk32,
  input  logic              i_rst,
  input  logic              i_alloc,
  input  logic [RANK_W-1:0] i_slot,
  output logic [RANK_W-1:0] o_oldest
);
  logic [RANK_W-1:0] r_rank [NUM_VOICES];
  logic [RANK_W-1:0] w_sel_rank;
  logic [RANK_W-1:0] w_oldest;

  always_comb begin
    w_sel_rank = '0;
    w_oldest   = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (i_slot == RANK_W'(i)) w_sel_rank = r_rank[i];
      if (r_rank[i] == RANK_W'(NUM_VOICES - 1)) w_oldest = RANK_W'(i);
    end
  end

  // Slots younger than the chosen one age by one; the permutation is preserved.
  always_ff @(posedge i_clk32) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_VOICES; i++) r_rank[i] <= RANK_W'(i);
    end else if (i_alloc) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (i_slot == RANK_W'(i))       r_rank[i] <= '0;
        else if (r_rank[i] < w_sel_rank) r_rank[i] <= r_rank[i] + 1'b1;
      end
    end
  end

  assign o_oldest = w_oldest;
endmodule

// File: rtl/midi_voice_alloc.sv
// Polyphonic voice allocator: maps note-on/off pulses onto NUM_VOICES slots.
// VOICE_STEAL_EN: when defined, a full bank steals the oldest slot instead of dropping.
module midi_voice_alloc
  import synth_voice_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int OMNI       = 1,
  parameter int CHANNEL    = 0
) (
  input  logic                         i_clk32,
  input  logic                         i_rst,
  input  logic                         i_note_pressed,
  input  logic                         i_note_released,
  input  logic [NOTE_W-1:0]            i_note,
  input  logic [VEL_W-1:0]             i_velocity,
  input  logic [CHAN_W-1:0]            i_channel,
  output logic [NUM_VOICES-1:0]        o_voice_gate,
  output logic [NUM_VOICES-1:0]        o_voice_trig,
  output logic [NOTE_W*NUM_VOICES-1:0] o_voice_note,
  output logic [VEL_W*NUM_VOICES-1:0]  o_voice_vel,
  output logic [3:0]                   o_active_cnt,
  output logic [7:0]                   o_drop_cnt
);
  voice_t                  r_voice     [NUM_VOICES];
  voice_t                  w_voice_nxt [NUM_VOICES];
  logic [NUM_VOICES-1:0]   r_trig, w_trig_nxt, w_gate_nxt;
  logic [3:0]              r_active;
  logic [7:0]              r_drop;
  logic                    w_accept, w_rel, w_on;
  logic                    w_match_hit, w_free_hit, w_alloc, w_drop;
  logic [RANK_W-1:0]       w_match_idx, w_free_idx, w_slot, w_oldest;

  // Velocity-0 note-on is a release; a release wins over a simultaneous press.
  assign w_accept = (OMNI != 0) || (i_channel == CHAN_W'(CHANNEL));
  assign w_rel    = w_accept && (i_note_released || (i_note_pressed && i_velocity == '0));
  assign w_on     = w_accept && i_note_pressed && !i_note_released && (i_velocity != '0);

  always_comb begin
    w_match_hit = 1'b0;
    w_match_idx = '0;
    w_free_hit  = 1'b0;
    w_free_idx  = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (r_voice[i].gate && r_voice[i].note == i_note && r_voice[i].chan == i_channel) begin
        w_match_hit = 1'b1;
        w_match_idx = RANK_W'(i);
      end
      if (!r_voice[i].gate) begin
        w_free_hit = 1'b1;
        w_free_idx = RANK_W'(i);
      end
    end
  end

  always_comb begin
    w_alloc = 1'b0;
    w_drop  = 1'b0;
    w_slot  = w_oldest;
    if (w_on) begin
      if (w_match_hit) begin
        w_alloc = 1'b1;
        w_slot  = w_match_idx;
      end else if (w_free_hit) begin
        w_alloc = 1'b1;
        w_slot  = w_free_idx;
      end else begin
`ifdef VOICE_STEAL_EN
        w_alloc = 1'b1;
`else
        w_drop  = 1'b1;
`endif
      end
    end
  end

  always_comb begin
    w_trig_nxt = '0;
    w_gate_nxt = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      w_voice_nxt[i] = r_voice[i];
      if (w_rel && r_voice[i].gate && r_voice[i].note == i_note && r_voice[i].chan == i_channel)
        w_voice_nxt[i].gate = 1'b0;
      if (w_alloc && w_slot == RANK_W'(i)) begin
        w_voice_nxt[i] = '{gate: 1'b1, note: i_note, vel: i_velocity, chan: i_channel};
        w_trig_nxt[i]  = 1'b1;
      end
      w_gate_nxt[i] = w_voice_nxt[i].gate;
    end
  end

  always_ff @(posedge i_clk32) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_VOICES; i++) r_voice[i] <= '0;
      r_trig   <= '0;
      r_active <= '0;
      r_drop   <= '0;
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) r_voice[i] <= w_voice_nxt[i];
      r_trig   <= w_trig_nxt;
      r_active <= count_gates(8'(w_gate_nxt));
      if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
    end
  end

  voice_rank_tracker #(.NUM_VOICES(NUM_VOICES)) u_rank (
    .i_clk32  (i_clk32),
    .i_rst    (i_rst),
    .i_alloc  (w_alloc),
    .i_slot   (w_slot),
    .o_oldest (w_oldest)
  );

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_out
    assign o_voice_gate[g]                  = r_voice[g].gate;
    assign o_voice_note[g*NOTE_W +: NOTE_W] = r_voice[g].note;
    assign o_voice_vel[g*VEL_W +: VEL_W]    = r_voice[g].vel;
  end
  assign o_voice_trig = r_trig;
  assign o_active_cnt = r_active;
  assign o_drop_cnt   = r_drop;
endmodule

// File: tb/tb_midi_voice_alloc.sv
// Directed plus randomized check of midi_voice_alloc against an age-queue reference model.
module tb_midi_voice_alloc;
  localparam int NV   = 4;
  localparam int OMNI = 0;
  localparam int CHAN = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            pr = 1'b0, rl = 1'b0;
  logic [6:0]      note = '0, vel = '0;
  logic [3:0]      ch = '0;
  logic [NV-1:0]   gate, trig;
  logic [7*NV-1:0] vnote, vvel;
  logic [3:0]      act;
  logic [7:0]      drop;

  always #5 clk = ~clk;

  midi_voice_alloc #(.NUM_VOICES(NV), .OMNI(OMNI), .CHANNEL(CHAN)) u_dut (
    .i_clk32(clk), .i_rst(rst), .i_note_pressed(pr), .i_note_released(rl),
    .i_note(note), .i_velocity(vel), .i_channel(ch),
    .o_voice_gate(gate), .o_voice_trig(trig), .o_voice_note(vnote), .o_voice_vel(vvel),
    .o_active_cnt(act), .o_drop_cnt(drop)
  );

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: per-slot records plus an allocation-order queue (front = newest).
  bit        m_gate [NV];
  int        m_note [NV], m_vel [NV], m_chan [NV];
  int        m_age[$];
  bit [NV-1:0] m_trig;
  int        m_drop;

  function automatic void m_reset();
    m_age = {};
    for (int i = 0; i < NV; i++) begin
      m_gate[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_chan[i] = 0;
      m_age.push_back(i);
    end
    m_trig = '0;
    m_drop = 0;
  endfunction

  function automatic void m_step(bit p, bit r, int n, int v, int c);
    int s;
    bit acc;
    acc = (OMNI != 0) || (c == CHAN);
    m_trig = '0;
    if (!acc) return;
    if (r || (p && v == 0)) begin
      for (int i = 0; i < NV; i++)
        if (m_gate[i] && m_note[i] == n && m_chan[i] == c) m_gate[i] = 0;
    end else if (p) begin
      s = -1;
      for (int i = 0; i < NV; i++)
        if (s < 0 && m_gate[i] && m_note[i] == n && m_chan[i] == c) s = i;
      for (int i = 0; i < NV; i++)
        if (s < 0 && !m_gate[i]) s = i;
`ifdef VOICE_STEAL_EN
      if (s < 0) s = m_age[m_age.size()-1];
`endif
      if (s < 0) begin
        if (m_drop < 255) m_drop++;
      end else begin
        m_gate[s] = 1; m_note[s] = n; m_vel[s] = v; m_chan[s] = c;
        m_trig[s] = 1'b1;
        for (int k = 0; k < m_age.size(); k++)
          if (m_age[k] == s) begin m_age.delete(k); break; end
        m_age.push_front(s);
      end
    end
  endfunction

  task automatic compare_all();
    logic [NV-1:0]   eg;
    logic [7*NV-1:0] en, ev;
    int              cnt;
    cnt = 0;
    for (int i = 0; i < NV; i++) begin
      eg[i] = m_gate[i];
      en[i*7 +: 7] = 7'(m_note[i]);
      ev[i*7 +: 7] = 7'(m_vel[i]);
      cnt += int'(m_gate[i]);
    end
    chk("gate",   64'(gate),  64'(eg));
    chk("trig",   64'(trig),  64'(m_trig));
    chk("note",   64'(vnote), 64'(en));
    chk("vel",    64'(vvel),  64'(ev));
    chk("active", 64'(act),   64'(cnt));
    chk("drop",   64'(drop),  64'(m_drop));
  endtask

  task automatic step(input bit p, input bit r, input int n, input int v, input int c);
    @(negedge clk);
    pr = p; rl = r; note = 7'(n); vel = 7'(v); ch = 4'(c);
    @(posedge clk);
    #1;
    pr = 1'b0; rl = 1'b0;
    m_step(p, r, n, v, c);
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_reset();
    compare_all();
  endtask

  task automatic on(input int n, input int v);
    step(1, 0, n, v, CHAN);
  endtask

  task automatic off(input int n);
    step(0, 1, n, 64, CHAN);
  endtask

  initial begin
    m_reset();
    do_reset();
    chk("rst_gate", 64'(gate), 64'd0);

    on(60, 100);
    chk("t1_gate", 64'(gate), 64'b0001);
    chk("t1_trig", 64'(trig), 64'b0001);
    chk("t1_note0", 64'(vnote[6:0]), 64'd60);
    chk("t1_vel0", 64'(vvel[6:0]), 64'd100);
    chk("t1_act", 64'(act), 64'd1);

    on(62, 90); on(64, 80); on(67, 70);
    off(62);
    chk("t2_gate", 64'(gate), 64'b1101);
    chk("t2_note1", 64'(vnote[13:7]), 64'd62);
    on(70, 60);
    chk("t2_trig", 64'(trig), 64'b0010);

    on(72, 50);
`ifdef VOICE_STEAL_EN
    chk("t3_note0", 64'(vnote[6:0]), 64'd72);
    chk("t3_trig", 64'(trig), 64'b0001);
    chk("t3_gate", 64'(gate), 64'b1111);
`else
    chk("t4_note0", 64'(vnote[6:0]), 64'd60);
    chk("t4_trig", 64'(trig), 64'd0);
    chk("t4_drop", 64'(drop), 64'd1);
`endif
    for (int k = 0; k < 300; k++) on(80 + (k % 7), 40);
`ifdef VOICE_STEAL_EN
    chk("t4_drop_sat", 64'(drop), 64'd0);
`else
    chk("t4_drop_sat", 64'(drop), 64'd255);
`endif

    do_reset();
    on(60, 100);
    on(60, 50);
    chk("t5_trig", 64'(trig), 64'b0001);
    chk("t5_vel0", 64'(vvel[6:0]), 64'd50);
    chk("t5_act", 64'(act), 64'd1);
    on(60, 0);
    chk("t5_gate0", 64'(gate[0]), 64'd0);

    step(1, 0, 60, 100, 3);
    chk("t6_chan", 64'(gate), 64'd0);
    on(61, 90);
    step(1, 1, 61, 90, CHAN);
    chk("t6_both_gate", 64'(gate), 64'd0);
    chk("t6_both_trig", 64'(trig), 64'd0);
    on(60, 1); on(62, 2); on(64, 3); on(67, 4);
    chk("t6_full", 64'(gate), 64'b1111);
    do_reset();
    chk("t6_rst_gate", 64'(gate), 64'd0);
    chk("t6_rst_act", 64'(act), 64'd0);

    for (int k = 0; k < 800; k++) begin
      int kind, n, v, c;
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
      end else begin
        kind = $urandom_range(0, 9);
        n = 60 + $urandom_range(0, 5);
        v = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 127);
        c = ($urandom_range(0, 3) == 0) ? 3 : CHAN;
        if (kind <= 5)      step(1, 0, n, v, c);
        else if (kind <= 8) step(0, 1, n, v, c);
        else                step(1, 1, n, v, c);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
